// File: rtl/ro_cal_pkg.sv
// Shared types and helpers for the ring-oscillator calibration sequencer.
// Combinational helpers only: no latency, no flow control.
package ro_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    COMPARE,
    FINISH
  } ro_cal_state_t;

  localparam int unsigned THERM_MAX = 64;
  localparam int unsigned ABS_W     = 32;

  // Bits [code-1:0] set; callers truncate to their bus width.
  function automatic logic [THERM_MAX-1:0] therm_encode(input int unsigned code);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      t[i] = (i < code);
    end
    return t;
  endfunction

  function automatic logic [ABS_W:0] abs_diff(input logic [ABS_W-1:0] a,
                                              input logic [ABS_W-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/ro_tick_counter.sv
// Saturating tick counter with synchronous clear (priority) and enable.
// Count visible one cycle after an enabled tick; no backpressure.
module ro_tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ro_cal_sequencer.sv
// Sweeps RO tap codes, measures ticks per window, applies the code closest to target.
// Full sweep: (NUM_STAGES+1)*(SETTLE+WINDOW+1)+2 cycles; start ignored while busy. Option: RO_CAL_EARLY_EXIT_EN.
module ro_cal_sequencer
  import ro_cal_pkg::*;
#(
  parameter  int NUM_STAGES    = 15,
  parameter  int CNT_W         = 16,
  parameter  int SETTLE_CYCLES = 64,
  parameter  int WINDOW_CYCLES = 1024,
  localparam int CW            = $clog2(NUM_STAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [CNT_W-1:0]      target_count,
  input  logic                  ro_tick,
  output logic [NUM_STAGES-1:0] mux_select,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         best_code,
  output logic [CNT_W-1:0]      best_count,
  output logic [CNT_W-1:0]      last_count
);

  localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  ro_cal_state_t          state_q;
  logic [CW-1:0]          code_q;
  logic [TMR_W-1:0]       tmr_q;
  logic [CNT_W-1:0]       target_q;
  logic [CNT_W:0]         best_err_q;
  logic [NUM_STAGES-1:0]  mux_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CW-1:0]          best_code_q;
  logic [CNT_W-1:0]       best_count_q;
  logic [CNT_W-1:0]       last_count_q;

  logic [CNT_W-1:0]       tick_cnt;
  logic                   cnt_clr_d;
  logic                   cnt_en_d;
  logic [CNT_W:0]         err_d;
  logic                   exit_d;

  assign cnt_clr_d = (state_q == SETTLE) && (tmr_q == '0);
  assign cnt_en_d  = (state_q == MEASURE) && ro_tick;
  assign err_d     = (CNT_W+1)'(abs_diff(ABS_W'(tick_cnt), ABS_W'(target_q)));

`ifdef RO_CAL_EARLY_EXIT_EN
  assign exit_d = (code_q == CW'(NUM_STAGES)) || (err_d == '0);
`else
  assign exit_d = (code_q == CW'(NUM_STAGES));
`endif

  ro_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clr_i   (cnt_clr_d),
    .en_i    (cnt_en_d),
    .count_o (tick_cnt)
  );

  // The one timer serves both the settle wait and the measurement window.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      code_q       <= '0;
      tmr_q        <= '0;
      target_q     <= '0;
      best_err_q   <= '0;
      mux_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_code_q  <= '0;
      best_count_q <= '0;
      last_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            target_q   <= target_count;
            code_q     <= '0;
            mux_q      <= '0;
            best_err_q <= '1;
            tmr_q      <= TMR_W'(SETTLE_CYCLES - 1);
            busy_q     <= 1'b1;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_q == '0) begin
            tmr_q   <= TMR_W'(WINDOW_CYCLES - 1);
            state_q <= MEASURE;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        MEASURE: begin
          if (tmr_q == '0) begin
            state_q <= COMPARE;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        COMPARE: begin
          last_count_q <= tick_cnt;
          // Strict less-than keeps the lower code on a tie.
          if (err_d < best_err_q) begin
            best_err_q   <= err_d;
            best_code_q  <= code_q;
            best_count_q <= tick_cnt;
          end
          if (exit_d) begin
            state_q <= FINISH;
          end else begin
            code_q  <= code_q + CW'(1);
            mux_q   <= NUM_STAGES'(therm_encode(32'(code_q) + 32'd1));
            tmr_q   <= TMR_W'(SETTLE_CYCLES - 1);
            state_q <= SETTLE;
          end
        end
        FINISH: begin
          mux_q   <= NUM_STAGES'(therm_encode(32'(best_code_q)));
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mux_select = mux_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_code  = best_code_q;
  assign best_count = best_count_q;
  assign last_count = last_count_q;

endmodule

// File: tb/tb_ro_cal_sequencer.sv
// Scoreboard bench for ro_cal_sequencer: per-code tick budgets drive a spec-level model.
`timescale 1ns/1ps
module tb_ro_cal_sequencer;

  localparam int NS       = 15;
  localparam int CNT_W    = 8;
  localparam int S        = 64;
  localparam int W        = 1024;
  localparam int CW       = 4;
  localparam int P        = S + W + 1;
  localparam int FULL_LAT = (NS + 1) * P + 2;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] target_count = '0;
  logic             ro_tick = 1'b0;
  logic [NS-1:0]    mux_select;
  logic             busy;
  logic             done;
  logic [CW-1:0]    best_code;
  logic [CNT_W-1:0] best_count;
  logic [CNT_W-1:0] last_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int            code;
    int            cnt;
    int            last;
    logic [NS-1:0] mux;
    int            lat;
    int            start_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;
  int   n_arr[16];

  ro_cal_sequencer #(
    .NUM_STAGES    (NS),
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (S),
    .WINDOW_CYCLES (W)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .target_count (target_count),
    .ro_tick      (ro_tick),
    .mux_select   (mux_select),
    .busy         (busy),
    .done         (done),
    .best_code    (best_code),
    .best_count   (best_count),
    .last_count   (last_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Closest clipped count wins, lowest code on ties; optional stop on an exact hit.
  function automatic exp_t model(input int n[16], input int tgt);
    exp_t e;
    int best_err = 1 << 30;
    int c, err;
    int last_k = NS;
    e.code = 0; e.cnt = 0; e.last = 0; e.start_cyc = 0;
    for (int k = 0; k <= NS; k++) begin
      c   = (n[k] > SAT) ? SAT : n[k];
      err = (c > tgt) ? c - tgt : tgt - c;
      if (err < best_err) begin
        best_err = err;
        e.code   = k;
        e.cnt    = c;
      end
      e.last = c;
      last_k = k;
`ifdef RO_CAL_EARLY_EXIT_EN
      if (err == 0) break;
`endif
    end
    e.mux = NS'((1 << e.code) - 1);
    e.lat = (last_k + 1) * P + 2;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!RESET && done) begin
      if (done_prev) check("done_width", 1, 0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("best_code", best_code, mon_e.code);
        check("best_count", best_count, mon_e.cnt);
        check("last_count", last_count, mon_e.last);
        check("mux_select", mux_select, mon_e.mux);
        check("done_latency", cyc - mon_e.start_cyc, mon_e.lat);
        check("busy_at_done", busy, 0);
      end
    end
    done_prev <= done;
  end

  task automatic run_sweep(input int n[16], input int tgt, input bit sat, input bit poke);
    exp_t e;
    int k, off;
    int busy_bad = 0;
    @(posedge CLK); #1;
    e = model(n, tgt);
    e.start_cyc = cyc;
    sb_q.push_back(e);
    start = 1'b1;
    target_count = CNT_W'(tgt);
    for (int c = 1; c <= FULL_LAT + 4; c++) begin
      @(posedge CLK); #1;
      start = poke && (c == 500);
      target_count = CNT_W'($urandom);
      if (sat) begin
        ro_tick = 1'b1;
      end else begin
        k   = (c - 1) / P;
        off = (c - 1) % P;
        if (k <= NS && off >= S && off < S + W) ro_tick = ((off - S) < n[k]);
        else ro_tick = 1'($urandom);
      end
      if (c < e.lat && busy !== 1'b1) busy_bad++;
      if (c == e.lat && busy !== 1'b0) busy_bad++;
    end
    start = 1'b0;
    ro_tick = 1'b0;
    check("busy_window", busy_bad, 0);
    if (sb_q.size() != 0) begin
      check("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int v;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_mux", mux_select, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_code", best_code, 0);
    check("rst_best_count", best_count, 0);
    check("rst_last_count", last_count, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Abort a sweep in code 1's window.
    @(posedge CLK); #1;
    start = 1'b1;
    target_count = 8'd50;
    for (int c = 1; c < P + S + 100; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      ro_tick = 1'($urandom);
    end
    check("pre_abort_busy", busy, 1);
    check("pre_abort_mux", mux_select, 1);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_mux", mux_select, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_last_count", last_count, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    ro_tick = 1'b0;

    // Basic 10*code sweep with a start poke while busy.
    for (int k = 0; k < 16; k++) n_arr[k] = 10 * k;
    run_sweep(n_arr, 73, 1'b0, 1'b1);

    // Tie between codes 7 and 8; others random and clear of the target.
    for (int k = 0; k < 16; k++) begin
      do v = $urandom_range(0, 400); while (v >= 70 && v <= 80);
      n_arr[k] = v;
    end
    n_arr[7] = 70;
    n_arr[8] = 80;
    run_sweep(n_arr, 75, 1'b0, 1'b0);

    // Constant ticks saturate every window; random target.
    for (int k = 0; k < 16; k++) n_arr[k] = W;
    run_sweep(n_arr, $urandom_range(0, SAT), 1'b1, 1'b0);

    // Exact hit at code 3.
    for (int k = 0; k < 16; k++) n_arr[k] = 10 * k;
    run_sweep(n_arr, 30, 1'b0, 1'b0);

    repeat (4) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
